// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl
//   Scans a 4x4 active-low matrix keypad one column at a time, debounces
//   press and release, and reports one event per physical key press.
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   row[3:0]   keypad row lines, active low, asynchronous (row[3] = top row)
//   col[3:0]   column drive, one-hot low (4'b0111 = column 0, leftmost)
//   key_code   last accepted key (hex), held until the next accepted key
//   key_valid  one-cycle strobe marking a newly accepted key
//   key_held   high while the accepted key remains pressed
module keypad_scan_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned STABLE_CYCLES = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int unsigned SW = $clog2(SETTLE_CYCLES) + 1;
    localparam int unsigned TW = $clog2(STABLE_CYCLES) + 1;

    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
    localparam logic [TW-1:0] STABLE_LAST = TW'(STABLE_CYCLES);
    localparam logic [TW-1:0] REL_LAST    = TW'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        PRESSED,
        HELD
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    rs_meta_q, rs_meta_d;
    logic [3:0]    rs_q, rs_d;
    logic [1:0]    col_idx_q, col_idx_d;
    logic [3:0]    col_q, col_d;
    logic [SW-1:0] settle_q, settle_d;
    logic [TW-1:0] stable_q, stable_d;
    logic [TW-1:0] rel_q, rel_d;
    logic [3:0]    pat_q, pat_d;
    logic [3:0]    key_code_q, key_code_d;
    logic          key_held_q, key_held_d;

    // Highest-priority (topmost) low row of the captured pattern, mapped
    // through the keypad legend for column c.
    function automatic logic [3:0] key_lookup(input logic [1:0] c, input logic [3:0] p);
        logic [1:0] r;
        logic [3:0] code;
        if (!p[3])      r = 2'd3;
        else if (!p[2]) r = 2'd2;
        else if (!p[1]) r = 2'd1;
        else            r = 2'd0;
        case ({c, r})
            4'b00_11: code = 4'h1;
            4'b00_10: code = 4'h4;
            4'b00_01: code = 4'h7;
            4'b00_00: code = 4'h0;
            4'b01_11: code = 4'h2;
            4'b01_10: code = 4'h5;
            4'b01_01: code = 4'h8;
            4'b01_00: code = 4'hF;
            4'b10_11: code = 4'h3;
            4'b10_10: code = 4'h6;
            4'b10_01: code = 4'h9;
            4'b10_00: code = 4'hE;
            4'b11_11: code = 4'hA;
            4'b11_10: code = 4'hB;
            4'b11_01: code = 4'hC;
            default:  code = 4'hD;
        endcase
        return code;
    endfunction

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= SCAN;
            rs_meta_q  <= '1;
            rs_q       <= '1;
            col_idx_q  <= '0;
            col_q      <= 4'b0111;
            settle_q   <= '0;
            stable_q   <= '0;
            rel_q      <= '0;
            pat_q      <= '1;
            key_code_q <= '0;
            key_held_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rs_meta_q  <= rs_meta_d;
            rs_q       <= rs_d;
            col_idx_q  <= col_idx_d;
            col_q      <= col_d;
            settle_q   <= settle_d;
            stable_q   <= stable_d;
            rel_q      <= rel_d;
            pat_q      <= pat_d;
            key_code_q <= key_code_d;
            key_held_q <= key_held_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        rs_meta_d  = row;
        rs_d       = rs_meta_q;
        col_idx_d  = col_idx_q;
        settle_d   = settle_q;
        stable_d   = stable_q;
        rel_d      = rel_q;
        pat_d      = pat_q;
        key_code_d = key_code_q;
        key_held_d = key_held_q;

        case (state_q)
            SCAN: begin
                if (settle_q == SETTLE_LAST) begin
                    settle_d = '0;
                    if (rs_q == 4'b1111) begin
                        col_idx_d = col_idx_q + 2'd1;
                    end else begin
                        pat_d    = rs_q;
                        stable_d = TW'(1);
                        state_d  = DEBOUNCE;
                    end
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end
            DEBOUNCE: begin
                // settle_q is already zero here, so falling back to SCAN
                // restarts the settle count on the same column.
                if (rs_q != pat_q) begin
                    state_d = SCAN;
                end else if (stable_q == STABLE_LAST) begin
                    // Code is loaded on entry to PRESSED so the new value is
                    // on key_code during the key_valid cycle itself.
                    state_d    = PRESSED;
                    key_code_d = key_lookup(col_idx_q, pat_q);
                end else begin
                    stable_d = stable_q + 1'b1;
                end
            end
            PRESSED: begin
                state_d    = HELD;
                key_held_d = 1'b1;
                rel_d      = '0;
            end
            HELD: begin
                if (rs_q == 4'b1111) begin
                    if (rel_q == REL_LAST) begin
                        state_d    = SCAN;
                        key_held_d = 1'b0;
                        col_idx_d  = col_idx_q + 2'd1;
                        settle_d   = '0;
                    end else begin
                        rel_d = rel_q + 1'b1;
                    end
                end else begin
                    rel_d = '0;
                end
            end
            default: state_d = SCAN;
        endcase

        col_d = ~(4'b1000 >> col_idx_d);
    end

    // Outputs
    always_comb begin
        key_valid = (state_q == PRESSED);
        col       = col_q;
        key_code  = key_code_q;
        key_held  = key_held_q;
    end

endmodule
